// File: rtl/avalon_st_result_depacketizer.sv
// Receive stage: assembles DSZ-bit Avalon-ST beats (little-endian) into one RSZ-bit
// result, hands it over on a valid/ready handshake and counts framing errors.
module avalon_st_result_depacketizer #(
    parameter int DSZ = 8,
    parameter int RSZ = 64,
    parameter int ECW = 8
) (
    input  logic           clk,
    input  logic           _rst,
    input  logic           startofpacket_in,
    input  logic           endofpacket_in,
    input  logic [DSZ-1:0] data_in,
    input  logic           valid_in,
    output logic           ready_out,
    output logic [RSZ-1:0] res,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           err_pulse,
    output logic [ECW-1:0] err_cnt
);

    localparam int BEATS = RSZ / DSZ;
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [IW-1:0]  LAST_IDX = IW'(BEATS - 1);
    localparam logic [IW-1:0]  IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
    localparam logic [ECW-1:0] CNT_MAX  = {ECW{1'b1}};
    localparam logic [ECW-1:0] CNT_ONE  = ECW'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DROP    = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]     r_state;
    logic [IW-1:0]  r_idx;
    logic [RSZ-1:0] r_res;
    logic           r_ready;
    logic           r_valid;
    logic           r_err;
    logic [ECW-1:0] r_cnt;

    logic           w_acc;
    logic [1:0]     w_state_nxt;
    logic [IW-1:0]  w_idx_nxt;
    logic           w_store;
    logic [IW-1:0]  w_widx;
    logic           w_err;

    assign w_acc = valid_in && r_ready;

    // Framing decisions: next state, beat index, result write and error flag
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_store     = 1'b0;
        w_widx      = r_idx;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE, S_DROP: begin
                if (w_acc) begin
                    if (startofpacket_in) begin
                        if (endofpacket_in) begin
                            if (BEATS == 1) begin
                                w_store     = 1'b1;
                                w_widx      = IDX_ZERO;
                                w_state_nxt = S_HOLD;
                                w_idx_nxt   = IDX_ZERO;
                            end else begin
                                // a one-beat packet is only an error when not already draining
                                w_err       = (r_state == S_IDLE);
                                w_state_nxt = S_IDLE;
                                w_idx_nxt   = IDX_ZERO;
                            end
                        end else begin
                            w_store     = 1'b1;
                            w_widx      = IDX_ZERO;
                            w_state_nxt = S_COLLECT;
                            w_idx_nxt   = IDX_ONE;
                        end
                    end else if (r_state == S_IDLE) begin
                        w_err = 1'b1;
                    end else if (endofpacket_in) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = IDX_ZERO;
                    end else begin
                        w_state_nxt = S_DROP;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_COLLECT: begin
                if (w_acc) begin
                    if (startofpacket_in) begin
                        w_err = 1'b1;
                        if (endofpacket_in) begin
                            w_state_nxt = S_IDLE;
                            w_idx_nxt   = IDX_ZERO;
                        end else begin
                            w_store   = 1'b1;
                            w_widx    = IDX_ZERO;
                            w_idx_nxt = IDX_ONE;
                        end
                    end else if (endofpacket_in) begin
                        if (r_idx == LAST_IDX) begin
                            w_store     = 1'b1;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                        w_idx_nxt = IDX_ZERO;
                    end else if (r_idx == LAST_IDX) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_DROP;
                        w_idx_nxt   = IDX_ZERO;
                    end else begin
                        w_store   = 1'b1;
                        w_idx_nxt = r_idx + IDX_ONE;
                    end
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = IDX_ZERO;
            end
        endcase
    end

    // State, result storage, handshake flags and saturating error counter
    always_ff @(posedge clk) begin
        if (!_rst) begin
            r_state <= S_IDLE;
            r_idx   <= IDX_ZERO;
            r_res   <= {RSZ{1'b0}};
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= {ECW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_store) begin
                r_res[w_widx*DSZ +: DSZ] <= data_in;
            end
            r_ready <= (w_state_nxt != S_HOLD);
            r_valid <= (w_state_nxt == S_HOLD);
            r_err   <= w_err;
            if (w_err && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign ready_out = r_ready;
    assign res       = r_res;
    assign res_valid = r_valid;
    assign err_pulse = r_err;
    assign err_cnt   = r_cnt;

endmodule

// File: tb/tb_avalon_st_result_depacketizer.sv
// Bench: vector table, directed corner sequences, then random beats against a
// queue-based packet model.
module tb_avalon_st_result_depacketizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sop = 1'b0;
    logic        eop = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [63:0] res;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [63:0] P_A = 64'd5792444;
    localparam logic [63:0] P_B = 64'd384;

    avalon_st_result_depacketizer #(.DSZ(8), .RSZ(64), .ECW(8)) dut (
        .clk(clk), ._rst(rst_n),
        .startofpacket_in(sop), .endofpacket_in(eop),
        .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .res(res), .res_valid(res_valid), .res_ready(res_ready),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic        s;
        logic        e;
        logic [7:0]  d;
        logic        rr;
        logic        x_rdy;
        logic        x_rv;
        logic        x_ep;
        logic [7:0]  x_cnt;
        logic [63:0] x_res;
        logic        chk_res;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic exp4(input string t, input logic r, input logic v, input logic p, input logic [7:0] c);
        chk({t, ".ready_out"}, 64'(ready_out), 64'(r));
        chk({t, ".res_valid"}, 64'(res_valid), 64'(v));
        chk({t, ".err_pulse"}, 64'(err_pulse), 64'(p));
        chk({t, ".err_cnt"},   64'(err_cnt),   64'(c));
    endtask

    task automatic beat(input logic s, input logic e, input logic [7:0] d, input logic rr);
        valid_in = 1'b1; sop = s; eop = e; data_in = d; res_ready = rr;
        tick();
    endtask

    task automatic idle(input logic rr);
        valid_in = 1'b0; sop = 1'b0; eop = 1'b0; res_ready = rr;
        tick();
    endtask

    task automatic send64(input logic [63:0] w, input logic rr);
        for (int k = 0; k < 8; k++) beat(k == 0, k == 7, w[k*8 +: 8], rr);
    endtask

    task automatic add(input logic rst, input logic v, input logic s, input logic e,
                       input logic [7:0] d, input logic rr, input logic xr, input logic xv,
                       input logic xp, input logic [7:0] xc, input logic [63:0] xres,
                       input logic cr);
        vec_t t;
        t.rst = rst; t.v = v; t.s = s; t.e = e; t.d = d; t.rr = rr;
        t.x_rdy = xr; t.x_rv = xv; t.x_ep = xp; t.x_cnt = xc; t.x_res = xres; t.chk_res = cr;
        tbl.push_back(t);
    endtask

    // Reference model: a packet is a queue of bytes; the result is their weighted sum.
    logic [7:0]  m_q[$];
    bit          m_coll, m_drop, m_hold, m_rdy, m_rv, m_ep;
    int          m_cnt;
    logic [63:0] m_res;

    task automatic model_step(input logic rst, input logic v, input logic s, input logic e,
                              input logic [7:0] d, input logic rr);
        bit acc;
        acc  = v && m_rdy;
        m_ep = 1'b0;
        if (!rst) begin
            m_q.delete();
            m_coll = 1'b0; m_drop = 1'b0; m_hold = 1'b0;
            m_rdy = 1'b0; m_rv = 1'b0; m_cnt = 0; m_res = 64'd0;
        end else begin
            if (m_hold) begin
                if (rr) m_hold = 1'b0;
            end else if (acc) begin
                if (s) begin
                    if (m_coll) m_ep = 1'b1;
                    m_q.delete();
                    if (e) begin
                        if (!m_coll && !m_drop) m_ep = 1'b1;
                        m_coll = 1'b0;
                    end else begin
                        m_q.push_back(d);
                        m_coll = 1'b1;
                    end
                    m_drop = 1'b0;
                end else if (m_coll) begin
                    if (e && m_q.size() == 7) begin
                        m_q.push_back(d);
                        m_res = 64'd0;
                        for (int k = 0; k < 8; k++) m_res = m_res + (64'(m_q[k]) << (8 * k));
                        m_hold = 1'b1; m_coll = 1'b0;
                    end else if (e) begin
                        m_ep = 1'b1; m_coll = 1'b0;
                    end else if (m_q.size() == 7) begin
                        m_ep = 1'b1; m_coll = 1'b0; m_drop = 1'b1;
                    end else begin
                        m_q.push_back(d);
                    end
                end else if (m_drop) begin
                    if (e) m_drop = 1'b0;
                end else begin
                    m_ep = 1'b1;
                end
            end
            m_rdy = !m_hold;
            m_rv  = m_hold;
            if (m_ep && m_cnt < 255) m_cnt++;
        end
    endtask

    initial begin
        int g_pos, g_len;
        logic r, v, s, e, rr;
        logic [7:0] d;

        // Table: reset, good packet, short packet, good packet
        add(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd0, 64'd0, 1);
        add(1, 0, 0, 0, 8'h00, 1, 1, 0, 0, 8'd0, 64'd0, 1);
        for (int k = 0; k < 8; k++)
            add(1, 1, k == 0, k == 7, P_A[k*8 +: 8], 1, k != 7, k == 7, 0, 8'd0, P_A, k == 7);
        add(1, 0, 0, 0, 8'h00, 1, 1, 0, 0, 8'd0, P_A, 1);
        add(1, 1, 1, 0, 8'h80, 0, 1, 0, 0, 8'd0, 64'd0, 0);
        add(1, 1, 0, 0, 8'h01, 0, 1, 0, 0, 8'd0, 64'd0, 0);
        add(1, 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'd0, 64'd0, 0);
        add(1, 1, 0, 1, 8'h00, 0, 1, 0, 1, 8'd1, 64'd0, 0);
        add(1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 8'd1, 64'd0, 0);
        for (int k = 0; k < 8; k++)
            add(1, 1, k == 0, k == 7, P_B[k*8 +: 8], 1, k != 7, k == 7, 0, 8'd1, P_B, k == 7);
        add(1, 0, 0, 0, 8'h00, 1, 1, 0, 0, 8'd1, P_B, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst; valid_in = tbl[i].v; sop = tbl[i].s; eop = tbl[i].e;
            data_in = tbl[i].d; res_ready = tbl[i].rr;
            tick();
            exp4($sformatf("vec%0d", i), tbl[i].x_rdy, tbl[i].x_rv, tbl[i].x_ep, tbl[i].x_cnt);
            if (tbl[i].chk_res) chk($sformatf("vec%0d.res", i), res, tbl[i].x_res);
        end

        // HOLD with consumer stalled; beats offered during HOLD must not be taken
        send64(P_B, 1'b0);
        exp4("hold_enter", 0, 1, 0, 8'd1);
        chk("hold_enter.res", res, P_B);
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 1'b0, 8'hAA, 1'b0);
            exp4($sformatf("hold%0d", i), 0, 1, 0, 8'd1);
            chk($sformatf("hold%0d.res", i), res, P_B);
        end
        beat(1'b1, 1'b0, 8'hAA, 1'b1);
        exp4("hold_hs", 1, 0, 0, 8'd1);
        idle(1'b0);
        exp4("hold_after", 1, 0, 0, 8'd1);
        chk("hold_after.res", res, P_B);

        // Ten-beat packet: error at beat 7, beats 8..9 dropped
        for (int k = 0; k < 10; k++) begin
            beat(k == 0, k == 9, 8'(k + 16), 1'b0);
            if (k == 7) exp4("long_err", 1, 0, 1, 8'd2);
            if (k == 9) exp4("long_eop", 1, 0, 0, 8'd2);
        end
        send64(P_B, 1'b0);
        exp4("long_next", 0, 1, 0, 8'd2);
        chk("long_next.res", res, P_B);
        idle(1'b1);
        exp4("long_hs", 1, 0, 0, 8'd2);

        // Stray beat in IDLE, then sop arriving mid-packet
        rst_n = 1'b0; idle(1'b0); rst_n = 1'b1; idle(1'b0);
        beat(1'b0, 1'b0, 8'h55, 1'b0);
        exp4("stray", 1, 0, 1, 8'd1);
        beat(1'b1, 1'b0, 8'h11, 1'b0);
        beat(1'b0, 1'b0, 8'h22, 1'b0);
        beat(1'b0, 1'b0, 8'h33, 1'b0);
        exp4("partial", 1, 0, 0, 8'd1);
        beat(1'b1, 1'b0, P_A[7:0], 1'b0);
        exp4("restart", 1, 0, 1, 8'd2);
        for (int k = 1; k < 8; k++) beat(1'b0, k == 7, P_A[k*8 +: 8], 1'b0);
        exp4("restart_done", 0, 1, 0, 8'd2);
        chk("restart_done.res", res, P_A);
        idle(1'b1);

        // Reset mid-packet, recovery, then error counter saturation
        for (int k = 0; k < 4; k++) beat(k == 0, 1'b0, P_A[k*8 +: 8], 1'b0);
        rst_n = 1'b0;
        beat(1'b0, 1'b0, 8'h00, 1'b0);
        exp4("midrst", 0, 0, 0, 8'd0);
        chk("midrst.res", res, 64'd0);
        rst_n = 1'b1;
        idle(1'b1);
        exp4("midrst_rel", 1, 0, 0, 8'd0);
        send64(P_A, 1'b1);
        exp4("midrst_pkt", 0, 1, 0, 8'd0);
        chk("midrst_pkt.res", res, P_A);
        idle(1'b1);
        for (int i = 0; i < 300; i++) begin
            beat(1'b0, 1'b0, 8'($urandom), 1'b0);
            if (i == 254 || i == 299) exp4($sformatf("sat%0d", i), 1, 0, 1, 8'd255);
            else chk($sformatf("sat%0d.cnt", i), 64'(err_cnt), (i < 255) ? 64'(i + 1) : 64'd255);
        end

        // Random beats against the model
        g_pos = 0; g_len = 8;
        for (int c = 0; c < 3000; c++) begin
            r  = (c == 0) ? 1'b0 : ($urandom_range(0, 499) != 0);
            v  = ($urandom_range(0, 3) != 0);
            s  = (g_pos == 0);
            e  = (g_pos == g_len - 1);
            if ($urandom_range(0, 15) == 0) s = ~s;
            if ($urandom_range(0, 15) == 0) e = ~e;
            d  = 8'($urandom);
            rr = 1'($urandom_range(0, 1));
            if (r && v && m_rdy) begin
                g_pos++;
                if (g_pos >= g_len) begin
                    g_pos = 0;
                    g_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 8;
                end
            end
            model_step(r, v, s, e, d, rr);
            rst_n = r; valid_in = v; sop = s; eop = e; data_in = d; res_ready = rr;
            tick();
            exp4($sformatf("rnd%0d", c), m_rdy, m_rv, m_ep, 8'(m_cnt));
            if (m_rv) chk($sformatf("rnd%0d.res", c), res, m_res);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/avalon_st_result_depacketizer.md
Name: avalon_st_result_depacketizer

Overview:
Master-side receive stage that consumes the Avalon-ST result stream returned by the multiplier slave. Collects DSZ-bit beats framed by startofpacket/endofpacket into one RSZ-bit product word. Presents the word to the host side over a valid/ready handshake. Detects and counts framing errors.

Parameters:
DSZ, 8, stream data width in bits.
RSZ, 64, result width in bits; must be an integer multiple of DSZ. BEATS = RSZ/DSZ is derived internally (8 by default).
ECW, 8, error counter width.

Ports:
clk  input  1  single clock
_rst  input  1  synchronous, active-low reset
startofpacket_in  input  1  first beat of packet
endofpacket_in  input  1  last beat of packet
data_in  input  DSZ  beat data
valid_in  input  1  beat valid
ready_out  output  1  stage can accept a beat
res  output  RSZ  assembled result
res_valid  output  1  res holds a complete result
res_ready  input  1  consumer takes res
err_pulse  output  1  one-cycle pulse per framing error
err_cnt  output  ECW  saturating framing-error count

Behaviour:
- Reset (_rst=0 at clk edge):
  - state=IDLE, beat index=0.
  - res=0, res_valid=0, ready_out=0, err_pulse=0, err_cnt=0.
  - ready_out is registered; it rises on the first edge with _rst=1.
  - Reset mid-packet or mid-HOLD discards all partial or held data.
- Beat accepted: valid_in && ready_out at the clk edge. No other input is sampled unless valid_in is high.
- Byte order: little-endian. Beat k (k=0 is the sop beat) is written to res[k*DSZ +: DSZ].
  - res is written only on accepted beats of a valid packet.
  - Partial writes stay invisible because res_valid=0.
  - res is not cleared after it is consumed.
- ready_out = 1 in IDLE, COLLECT and DROP; 0 in HOLD.
- States:
  - IDLE:
    - sop beat: store beat 0, index=1, go to COLLECT.
    - sop&eop beat with BEATS>1: short packet, error, stay IDLE.
    - Non-sop beat: discard, error.
  - COLLECT (index = next beat number):
    - sop beat: truncated previous packet; error; restart with this beat as beat 0, index=1.
    - eop beat with index==BEATS-1: store, go to HOLD.
    - eop beat with index<BEATS-1: short packet, error, go to IDLE.
    - Non-eop beat with index==BEATS-1: long packet, error, go to DROP (the beat is not stored).
    - Otherwise: store, index++.
  - DROP:
    - Discard beats.
    - eop beat: go to IDLE.
    - sop beat: start a new packet as in IDLE, no extra error.
    - sop&eop beat: go to IDLE.
  - HOLD:
    - res_valid=1; res is stable.
    - When res_ready=1: res_valid=0 and state=IDLE at the next edge, so ready_out=1 the cycle after the handshake.
- Latency: eop beat accepted at edge N gives res_valid=1 from edge N; the result is visible in the following cycle.
- Each error gives err_pulse=1 for exactly one cycle after the offending edge.
  - err_cnt increments with err_pulse.
  - err_cnt saturates at 2^ECW-1.
  - At most one error per accepted beat.
- res_ready while res_valid=0 is ignored.
- Simultaneous events:
  - valid_in with res_ready in HOLD: the beat is not accepted, because ready_out=0 that cycle.
  - The source must hold the beat until ready_out=1.

Test Plan:
- Reset, then the packet BC,62,58,00,00,00,00,00 (sop on beat 0, eop on beat 7), res_ready=1 -> res=64'd5792444 (10234*566), res_valid high one cycle, err_cnt=0.
- Packet 80,01,00×6 with res_ready=0 for 5 cycles, then 1 -> res=64'd384 (32*12) held stable. ready_out=0 throughout HOLD and =1 one cycle after the handshake; beats offered during HOLD are not accepted.
- sop beat then eop on beat 3 -> err_pulse once, err_cnt=1, res_valid stays 0. The following good packet of 384 is received correctly.
- 10-beat packet (no eop on beat 7) -> one error; beats 8..9 dropped through eop. The next good packet is received correctly.
- Beat without sop in IDLE, and a sop arriving mid-packet -> two errors, err_cnt=2. The restarted packet assembles correctly from the new sop.
- Assert _rst=0 at beat 4 of a packet -> all outputs zero next edge. After release, a full packet of 5792444 is received correctly; 300 consecutive bad beats -> err_cnt=255 (saturated).
